// File: rtl/riscv_ctrl_pkg.sv
// ============================================================================
//  Module   : riscv_ctrl_pkg
//  Brief    : Shared encodings for the multi-cycle RV32I control FSM.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXEC_R   = 4'd7,
        S_EXEC_I   = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10,
        S_JAL      = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'd0,
        ALU_OP_SUB   = 2'd1,
        ALU_OP_FUNCT = 2'd2
    } alu_op_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1000;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC  = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;
    localparam logic [1:0] SRC_B_RS2    = 2'b00;
    localparam logic [1:0] SRC_B_IMM    = 2'b01;
    localparam logic [1:0] SRC_B_FOUR   = 2'b10;
    localparam logic [1:0] RES_ALUOUT   = 2'b00;
    localparam logic [1:0] RES_MEMDATA  = 2'b01;
    localparam logic [1:0] RES_ALU      = 2'b10;

endpackage

`default_nettype wire

// File: rtl/riscv_alu_decoder.sv
// ============================================================================
//  Module   : riscv_alu_decoder
//  Brief    : Combinational ALU-control decode from alu_op, fn3, fn7[5], opcode[5].
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] fn3,
    input  logic       fn7_b5,
    input  logic       op_b5,
    output logic [3:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALU_OP_ADD: alu_ctrl = ALU_ADD;
            ALU_OP_SUB: alu_ctrl = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (fn3)
                    // fn7[5] on an I-type ADDI is immediate data, not a SUB request
                    3'b000:  alu_ctrl = (op_b5 && fn7_b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl = ALU_SLL;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b011:  alu_ctrl = ALU_SLT;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b101:  alu_ctrl = fn7_b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_AND;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/riscv_multicycle_ctrl.sv
// ============================================================================
//  Module   : riscv_multicycle_ctrl
//  Brief    : Multi-cycle RV32I-subset control FSM with retire counter and traps.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       fn3,
    input  logic [6:0]       fn7,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             adr_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       result_src,
    output logic [3:0]       alu_ctrl,
    output logic [3:0]       state_out,
    output logic             illegal,
    output logic [CNT_W-1:0] retired_count
);

    localparam int c_wait_w = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [c_wait_w-1:0] c_wait_last =
        (MEM_TIMEOUT > 0) ? c_wait_w'(MEM_TIMEOUT - 1) : '0;

    state_t              r_state;
    state_t              w_next;
    alu_op_t             w_alu_op;
    logic [c_wait_w-1:0] r_wait;
    logic [CNT_W-1:0]    r_retired;
    logic                w_mem_wait;
    logic                w_timeout;
    logic                w_retire;
    logic                w_enter_wait;
    logic                w_unused_fn7;

    assign w_unused_fn7 = &{1'b0, fn7[6], fn7[4:0]};

    assign w_mem_wait = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                        (r_state == S_MEMWRITE);
    // a handshake completing on the last allowed cycle takes priority over the trap
    assign w_timeout  = (MEM_TIMEOUT > 0) && w_mem_wait && !mem_ready &&
                        (r_wait == c_wait_last);
    assign w_retire   = (r_state == S_MEMWB) || (r_state == S_ALUWB) ||
                        (r_state == S_BEQ) || ((r_state == S_MEMWRITE) && mem_ready);
    assign w_enter_wait = (w_next != r_state) &&
                          ((w_next == S_FETCH) || (w_next == S_MEMREAD) ||
                           (w_next == S_MEMWRITE));

    riscv_alu_decoder u_alu_dec (
        .alu_op   (w_alu_op),
        .fn3      (fn3),
        .fn7_b5   (fn7[5]),
        .op_b5    (opcode[5]),
        .alu_ctrl (alu_ctrl)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        result_src = RES_ALUOUT;
        w_alu_op   = ALU_OP_ADD;
        illegal    = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready)      w_next = S_DECODE;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXEC_R;
                    OP_ITYPE:          w_next = S_EXEC_I;
                    OP_BRANCH:         w_next = (fn3 == 3'b000) ? S_BEQ : S_TRAP;
                    OP_JAL:            w_next = S_JAL;
                    default:           w_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                w_next    = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_read = 1'b1;
                adr_src  = 1'b1;
                if (mem_ready)      w_next = S_MEMWB;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_MEMWB: begin
                result_src = RES_MEMDATA;
                reg_write  = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready)      w_next = S_FETCH;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_EXEC_R: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_RS2;
                w_alu_op  = ALU_OP_FUNCT;
                w_next    = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                w_alu_op  = ALU_OP_FUNCT;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                w_next     = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_RS2;
                w_alu_op   = ALU_OP_SUB;
                result_src = RES_ALUOUT;
                pc_write   = zero;
                w_next     = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = SRC_A_OLDPC;
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALUOUT;
                pc_write   = 1'b1;
                w_next     = S_ALUWB;
            end
            S_TRAP: illegal = 1'b1;
            default: w_next = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait <= '0;
        end else if (w_enter_wait) begin
            r_wait <= '0;
        end else if (w_mem_wait && !mem_ready) begin
            r_wait <= r_wait + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign state_out     = r_state;
    assign retired_count = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_riscv_multicycle_ctrl.sv
// ============================================================================
//  Module   : tb_riscv_multicycle_ctrl
//  Brief    : Self-checking bench: per-cycle expectation queue plus vector table.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_multicycle_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, reset_b, zero, mem_ready, mem_ready_b;
    logic [6:0] opcode, fn7;
    logic [2:0] fn3;

    logic pc_write, ir_write, mem_read, mem_write, reg_write, adr_src, illegal;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [3:0] alu_ctrl, state_out;
    logic [31:0] retired_count;

    logic pc_write_b, ir_write_b, mem_read_b, mem_write_b, reg_write_b, adr_src_b, illegal_b;
    logic [1:0] alu_src_a_b, alu_src_b_b, result_src_b;
    logic [3:0] alu_ctrl_b, state_out_b;
    logic [3:0] retired_count_b;

    riscv_multicycle_ctrl #(.CNT_W(32), .MEM_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .fn3(fn3), .fn7(fn7), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .alu_ctrl(alu_ctrl), .state_out(state_out),
        .illegal(illegal), .retired_count(retired_count)
    );

    riscv_multicycle_ctrl #(.CNT_W(4), .MEM_TIMEOUT(4)) dut_b (
        .clk(clk), .reset(reset_b), .opcode(opcode), .fn3(fn3), .fn7(fn7), .zero(zero),
        .mem_ready(mem_ready_b), .pc_write(pc_write_b), .ir_write(ir_write_b),
        .mem_read(mem_read_b), .mem_write(mem_write_b), .reg_write(reg_write_b),
        .adr_src(adr_src_b), .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b),
        .result_src(result_src_b), .alu_ctrl(alu_ctrl_b), .state_out(state_out_b),
        .illegal(illegal_b), .retired_count(retired_count_b)
    );

    logic [16:0] ctl_a;
    assign ctl_a = {illegal, pc_write, ir_write, mem_read, mem_write, reg_write, adr_src,
                    alu_src_a, alu_src_b, result_src, alu_ctrl};

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_ret;

    typedef struct {
        logic        mr;
        logic        z;
        logic [3:0]  st;
        logic [16:0] ctl;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       z;
        int         n;
        logic [23:0] seq;
        logic [3:0] alu;
    } vec_t;
    vec_t vecs[$];

    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LW = 7'b0000011,
                           SW = 7'b0100011, BR = 7'b1100011, JL = 7'b1101111;
    localparam logic [23:0] SEQ_R = {4'd0, 4'd0, 4'd9, 4'd7, 4'd2, 4'd1};
    localparam logic [23:0] SEQ_I = {4'd0, 4'd0, 4'd9, 4'd8, 4'd2, 4'd1};

    // Expected control word per state, straight from the state/output table.
    function automatic logic [16:0] spec_out(input logic [3:0] st, input logic mr,
                                             input logic z, input logic [3:0] alu);
        logic pcw, irw, mrd, mwr, rw, adr, ill;
        logic [1:0] a, b, rs;
        logic [3:0] ac;
        {pcw, irw, mrd, mwr, rw, adr, ill} = '0;
        a = 2'b00; b = 2'b00; rs = 2'b00; ac = 4'b0000;
        case (st)
            4'd1:  begin mrd = 1; b = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
            4'd2:  begin a = 2'b01; b = 2'b01; end
            4'd3:  begin a = 2'b10; b = 2'b01; end
            4'd4:  begin mrd = 1; adr = 1; end
            4'd5:  begin rs = 2'b01; rw = 1; end
            4'd6:  begin mwr = 1; adr = 1; end
            4'd7:  begin a = 2'b10; ac = alu; end
            4'd8:  begin a = 2'b10; b = 2'b01; ac = alu; end
            4'd9:  rw = 1;
            4'd10: begin a = 2'b10; ac = 4'b0001; pcw = z; end
            4'd11: begin a = 2'b01; b = 2'b10; pcw = 1; end
            4'd12: ill = 1;
            default: ;
        endcase
        return {ill, pcw, irw, mrd, mwr, rw, adr, a, b, rs, ac};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic push_cyc(input logic [3:0] st, input logic mr, input logic z,
                            input logic [3:0] alu);
        exp_t e;
        e.mr = mr; e.z = z; e.st = st; e.ctl = spec_out(st, mr, z, alu);
        sb.push_back(e);
    endtask

    // Called at a falling edge; drives each queued cycle and checks it mid-cycle.
    task automatic drain(input string tag);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.mr;
            zero      = e.z;
            #1;
            check({tag, " state"}, 32'(state_out), 32'(e.st));
            check({tag, " ctl"}, 32'(ctl_a), 32'(e.ctl));
            @(negedge clk);
        end
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        opcode = op; fn3 = f3; fn7 = f7;
    endtask

    task automatic check_ret(input string tag);
        #1;
        check({tag, " retired"}, retired_count, exp_ret);
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        #1;
        check({tag, " rst state"}, 32'(state_out), 32'd0);
        check({tag, " rst ctl"}, 32'(ctl_a), 32'd0);
        check({tag, " rst retired"}, retired_count, 32'd0);
        exp_ret = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_b [7];
        vec_t v;
        reset = 1'b1; reset_b = 1'b1; mem_ready = 1'b0; mem_ready_b = 1'b0;
        zero = 1'b0; set_instr(7'd0, 3'd0, 7'd0);
        exp_ret = '0;

        add_vectors();

        @(negedge clk);
        check("reset state", 32'(state_out), 32'd0);
        check("reset ctl", 32'(ctl_a), 32'd0);
        check("reset retired", retired_count, 32'd0);
        reset = 1'b0;

        push_cyc(4'd0, 1'b1, 1'b0, 4'd0);
        drain("idle");

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            set_instr(v.op, v.f3, v.f7);
            for (int k = 0; k < v.n; k++) push_cyc(v.seq[4*k +: 4], 1'b1, v.z, v.alu);
            drain(v.name);
            exp_ret++;
            check_ret(v.name);
        end

        // LW with FETCH and MEMREAD wait states
        set_instr(LW, 3'b010, 7'd0);
        push_cyc(4'd1, 1'b0, 1'b0, 4'd0); push_cyc(4'd1, 1'b0, 1'b0, 4'd0);
        push_cyc(4'd1, 1'b1, 1'b0, 4'd0); push_cyc(4'd2, 1'b1, 1'b0, 4'd0);
        push_cyc(4'd3, 1'b0, 1'b0, 4'd0);
        for (int k = 0; k < 3; k++) push_cyc(4'd4, 1'b0, 1'b0, 4'd0);
        push_cyc(4'd4, 1'b1, 1'b0, 4'd0); push_cyc(4'd5, 1'b1, 1'b0, 4'd0);
        drain("lw_wait");
        exp_ret++;
        check_ret("lw_wait");

        // SW with MEMWRITE wait states; retires only once
        set_instr(SW, 3'b010, 7'd0);
        push_cyc(4'd1, 1'b1, 1'b0, 4'd0); push_cyc(4'd2, 1'b1, 1'b0, 4'd0);
        push_cyc(4'd3, 1'b0, 1'b0, 4'd0); push_cyc(4'd6, 1'b0, 1'b0, 4'd0);
        push_cyc(4'd6, 1'b0, 1'b0, 4'd0); push_cyc(4'd6, 1'b1, 1'b0, 4'd0);
        drain("sw_wait");
        exp_ret++;
        check_ret("sw_wait");

        // Illegal opcode: sticky trap, ignores memory handshake
        set_instr(7'b1111111, 3'd0, 7'd0);
        push_cyc(4'd1, 1'b1, 1'b0, 4'd0); push_cyc(4'd2, 1'b1, 1'b0, 4'd0);
        for (int k = 0; k < 20; k++) push_cyc(4'd12, k[0], 1'b0, 4'd0);
        drain("illegal");
        check_ret("illegal");
        pulse_reset("trap");

        // Branch with unsupported fn3 traps
        set_instr(BR, 3'b001, 7'd0);
        push_cyc(4'd0, 1'b1, 1'b0, 4'd0); push_cyc(4'd1, 1'b1, 1'b0, 4'd0);
        push_cyc(4'd2, 1'b1, 1'b0, 4'd0); push_cyc(4'd12, 1'b1, 1'b0, 4'd0);
        push_cyc(4'd12, 1'b0, 1'b0, 4'd0);
        drain("bne");
        pulse_reset("bne");

        // Reset in the middle of a stalled store
        set_instr(R, 3'b000, 7'd0);
        push_cyc(4'd0, 1'b1, 1'b0, 4'd0);
        for (int k = 0; k < 4; k++) push_cyc(SEQ_R[4*k +: 4], 1'b1, 1'b0, 4'd0);
        drain("pre_sw");
        exp_ret++;
        check_ret("pre_sw");
        set_instr(SW, 3'b010, 7'd0);
        push_cyc(4'd1, 1'b1, 1'b0, 4'd0); push_cyc(4'd2, 1'b1, 1'b0, 4'd0);
        push_cyc(4'd3, 1'b0, 1'b0, 4'd0); push_cyc(4'd6, 1'b0, 1'b0, 4'd0);
        drain("sw_stall");
        #1;
        check("sw_stall mem_write", 32'(mem_write), 32'd1);
        reset = 1'b1;
        #1;
        check("midreset mem_write", 32'(mem_write), 32'd0);
        check("midreset state", 32'(state_out), 32'd0);
        check("midreset retired", retired_count, 32'd0);

        // Second instance: MEM_TIMEOUT=4, CNT_W=4
        @(negedge clk);
        reset_b = 1'b0; mem_ready_b = 1'b0;
        exp_b = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd12, 4'd12};
        for (int k = 0; k < 7; k++) begin
            #1;
            check($sformatf("timeout cyc%0d state", k), 32'(state_out_b), 32'(exp_b[k]));
            @(negedge clk);
        end
        check("timeout illegal", 32'(illegal_b), 32'd1);

        reset_b = 1'b1;
        #1;
        check("b reset illegal", 32'(illegal_b), 32'd0);
        @(negedge clk);
        reset_b = 1'b0;
        set_instr(R, 3'b000, 7'd0);
        repeat (4) @(negedge clk);
        mem_ready_b = 1'b1;
        #1;
        check("last wait ready state", 32'(state_out_b), 32'd1);
        check("last wait ready ir_write", 32'(ir_write_b), 32'd1);
        @(negedge clk);
        #1;
        check("ready wins state", 32'(state_out_b), 32'd2);
        repeat (3) @(negedge clk);
        #1;
        check("wrap retired 1", 32'(retired_count_b), 32'd1);
        for (int i = 2; i <= 17; i++) begin
            repeat (4) @(negedge clk);
            #1;
            check($sformatf("wrap retired %0d", i), 32'(retired_count_b), 32'(i % 16));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    task automatic add_vec(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic z, input int n,
                           input logic [23:0] seq, input logic [3:0] alu);
        vec_t v;
        v.name = name; v.op = op; v.f3 = f3; v.f7 = f7; v.z = z;
        v.n = n; v.seq = seq; v.alu = alu;
        vecs.push_back(v);
    endtask

    task automatic add_vectors();
        add_vec("sub",  R, 3'b000, 7'b0100000, 1'b0, 4, SEQ_R, 4'b0001);
        add_vec("add",  R, 3'b000, 7'b0000000, 1'b0, 4, SEQ_R, 4'b0000);
        add_vec("and",  R, 3'b111, 7'b0000000, 1'b0, 4, SEQ_R, 4'b0010);
        add_vec("or",   R, 3'b110, 7'b0000000, 1'b0, 4, SEQ_R, 4'b0011);
        add_vec("xor",  R, 3'b100, 7'b0000000, 1'b0, 4, SEQ_R, 4'b0100);
        add_vec("slt",  R, 3'b010, 7'b0000000, 1'b0, 4, SEQ_R, 4'b0101);
        add_vec("sll",  R, 3'b001, 7'b0000000, 1'b0, 4, SEQ_R, 4'b0110);
        add_vec("srl",  R, 3'b101, 7'b0000000, 1'b0, 4, SEQ_R, 4'b0111);
        add_vec("sra",  R, 3'b101, 7'b0100000, 1'b0, 4, SEQ_R, 4'b1000);
        add_vec("addi", I, 3'b000, 7'b0100000, 1'b0, 4, SEQ_I, 4'b0000);
        add_vec("srai", I, 3'b101, 7'b0100000, 1'b0, 4, SEQ_I, 4'b1000);
        add_vec("srli", I, 3'b101, 7'b0000000, 1'b0, 4, SEQ_I, 4'b0111);
        add_vec("andi", I, 3'b111, 7'b0100000, 1'b0, 4, SEQ_I, 4'b0010);
        add_vec("xori", I, 3'b100, 7'b0000000, 1'b0, 4, SEQ_I, 4'b0100);
        add_vec("lw",   LW, 3'b010, 7'd0, 1'b0, 5, {4'd0, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1}, 4'd0);
        add_vec("sw",   SW, 3'b010, 7'd0, 1'b0, 4, {4'd0, 4'd0, 4'd6, 4'd3, 4'd2, 4'd1}, 4'd0);
        add_vec("beq_t", BR, 3'b000, 7'd0, 1'b1, 3, {4'd0, 4'd0, 4'd0, 4'd10, 4'd2, 4'd1}, 4'd0);
        add_vec("beq_n", BR, 3'b000, 7'd0, 1'b0, 3, {4'd0, 4'd0, 4'd0, 4'd10, 4'd2, 4'd1}, 4'd0);
        add_vec("jal",  JL, 3'b000, 7'd0, 1'b0, 4, {4'd0, 4'd0, 4'd9, 4'd11, 4'd2, 4'd1}, 4'd0);
    endtask

endmodule

`default_nettype wire
